// File: rtl/pwm_multi.sv
// pwm_multi: multi-channel double-buffered PWM generator on the 8-bit CSR bus
module pwm_multi #(
  parameter logic [4:0] BASE_ADDR = 5'h0,
  parameter int CHANNELS = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [4:0]          csr_a,
  input  logic [7:0]          csr_di,
  input  logic                csr_we,
  output logic [7:0]          csr_do,
  input  logic                pwm_ce,
  output logic [CHANNELS-1:0] pwm_out
);
  localparam logic [4:0] STAT_A = BASE_ADDR + 5'(2 * CHANNELS);
  logic [CHANNELS-1:0] en, inv, pend, ctrl_hit, duty_hit, wrap, load;
  logic [1:0] scale [CHANNELS];
  logic [6:0] cnt [CHANNELS];
  logic [6:0] top [CHANNELS];
  logic [7:0] duty [CHANNELS];
  logic [7:0] act [CHANNELS];
  logic [7:0] rd;
  logic resync;
  // address decode, wrap detection, reload events and the read mux
  always_comb begin
    resync = csr_we && csr_a == STAT_A && csr_di[7];
    rd = csr_a == STAT_A ? 8'(pend) : 8'h00;
    for (int i = 0; i < CHANNELS; i++) begin
      ctrl_hit[i] = csr_we && csr_a == BASE_ADDR + 5'(2 * i);
      duty_hit[i] = csr_we && csr_a == BASE_ADDR + 5'(2 * i + 1);
      top[i] = 7'h7f >> scale[i];
      wrap[i] = pwm_ce && en[i] && cnt[i] == top[i];
      load[i] = resync || (ctrl_hit[i] && csr_di[7] && (!en[i] || csr_di[1:0] != scale[i]));
      if (csr_a == BASE_ADDR + 5'(2 * i)) rd = {en[i], inv[i], 4'b0000, scale[i]};
      if (csr_a == BASE_ADDR + 5'(2 * i + 1)) rd = duty[i];
    end
  end
  // register file, per-channel counters, duty double buffer and outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      csr_do <= 8'h00;
      pwm_out <= '0;
      en <= '0;
      inv <= '0;
      pend <= '0;
      for (int i = 0; i < CHANNELS; i++) begin
        scale[i] <= 2'd0;
        cnt[i] <= 7'd0;
        duty[i] <= 8'h00;
        act[i] <= 8'h00;
      end
    end else begin
      csr_do <= rd;
      for (int i = 0; i < CHANNELS; i++) begin
        pwm_out[i] <= inv[i] ^ (en[i] & ({1'b0, cnt[i]} < act[i]));
        if (ctrl_hit[i]) begin
          en[i] <= csr_di[7];
          inv[i] <= csr_di[6];
          scale[i] <= csr_di[1:0];
        end
        if (duty_hit[i]) duty[i] <= csr_di;
        cnt[i] <= load[i] ? 7'd0 : (pwm_ce && en[i]) ? (wrap[i] ? 7'd0 : cnt[i] + 7'd1) : cnt[i];
        act[i] <= (load[i] || !en[i] || wrap[i]) ? duty[i] : act[i];
        pend[i] <= (load[i] || !en[i]) ? 1'b0 : duty_hit[i] ? 1'b1 : wrap[i] ? 1'b0 : pend[i];
      end
    end
  end
endmodule

// File: tb/tb_pwm_multi.sv
// tb_pwm_multi: directed self-checking bench for pwm_multi
module tb_pwm_multi;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [4:0] csr_a = 5'd0;
  logic [7:0] csr_di = 8'h00;
  logic csr_we = 1'b0;
  logic [7:0] csr_do;
  logic pwm_ce = 1'b0;
  logic [1:0] pwm_out;
  int checks = 0;
  int errors = 0;

  pwm_multi #(.BASE_ADDR(5'h0), .CHANNELS(2)) dut (
    .clk(clk), .rst(rst), .csr_a(csr_a), .csr_di(csr_di), .csr_we(csr_we),
    .csr_do(csr_do), .pwm_ce(pwm_ce), .pwm_out(pwm_out)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [4:0] a, input logic [7:0] d);
    csr_a = a;
    csr_di = d;
    csr_we = 1'b1;
    step();
    csr_we = 1'b0;
  endtask

  task automatic rd(input logic [4:0] a, output logic [7:0] d);
    csr_a = a;
    step();
    d = csr_do;
  endtask

  task automatic test_reset();
    logic [7:0] d;
    rst = 1'b1;
    repeat (3) step();
    checks++;
    if (pwm_out !== 2'b00) begin errors++; $display("FAIL reset_pwm_out got %b want 00", pwm_out); end
    rst = 1'b0;
    for (int a = 0; a < 6; a++) begin
      rd(5'(a), d);
      checks++;
      if (d !== 8'h00) begin errors++; $display("FAIL reset_read addr %0d got %02h want 00", a, d); end
    end
  endtask

  task automatic test_ch0_basic();
    int bad = 0;
    int highs = 0;
    wr(5'd1, 8'h40);
    wr(5'd0, 8'h80);
    pwm_ce = 1'b1;
    for (int j = 1; j <= 256; j++) begin
      step();
      highs += int'(pwm_out[0]);
      if (pwm_out[0] !== (((j - 1) % 128) < 64)) bad++;
    end
    checks++;
    if (bad !== 0) begin errors++; $display("FAIL ch0_pattern mismatched cycles got %0d want 0", bad); end
    checks++;
    if (highs !== 128) begin errors++; $display("FAIL ch0_high_count got %0d want 128", highs); end
    pwm_ce = 1'b0;
    wr(5'd0, 8'h00);
  endtask

  task automatic test_ch1_extremes();
    int highs = 0;
    wr(5'd3, 8'h10);
    wr(5'd2, 8'h83);
    pwm_ce = 1'b1;
    repeat (40) begin step(); highs += int'(pwm_out[1]); end
    checks++;
    if (highs !== 40) begin errors++; $display("FAIL ch1_full_duty highs got %0d want 40", highs); end
    wr(5'd3, 8'h00);
    repeat (20) step();
    highs = 0;
    repeat (32) begin step(); highs += int'(pwm_out[1]); end
    checks++;
    if (highs !== 0) begin errors++; $display("FAIL ch1_zero_duty highs got %0d want 0", highs); end
    wr(5'd2, 8'hC3);
    highs = 0;
    repeat (32) begin step(); highs += int'(pwm_out[1]); end
    checks++;
    if (highs !== 32) begin errors++; $display("FAIL ch1_inverted highs got %0d want 32", highs); end
    wr(5'd2, 8'h40);
    step();
    checks++;
    if (pwm_out[1] !== 1'b1) begin errors++; $display("FAIL ch1_idle_inv got %b want 1", pwm_out[1]); end
    pwm_ce = 1'b0;
    wr(5'd2, 8'h00);
  endtask

  task automatic test_double_buffer();
    logic [7:0] d;
    int highs = 0;
    wr(5'd1, 8'h20);
    wr(5'd0, 8'h80);
    pwm_ce = 1'b1;
    repeat (20) step();
    wr(5'd1, 8'h60);
    rd(5'd4, d);
    checks++;
    if (d !== 8'h01) begin errors++; $display("FAIL dbuf_stat_pending got %02h want 01", d); end
    repeat (105) begin step(); highs += int'(pwm_out[0]); end
    checks++;
    if (highs !== 10) begin errors++; $display("FAIL dbuf_old_duty highs got %0d want 10", highs); end
    rd(5'd4, d);
    checks++;
    if (d !== 8'h01) begin errors++; $display("FAIL dbuf_stat_before_wrap got %02h want 01", d); end
    rd(5'd4, d);
    checks++;
    if (d !== 8'h00) begin errors++; $display("FAIL dbuf_stat_after_wrap got %02h want 00", d); end
    highs = 0;
    repeat (128) begin step(); highs += int'(pwm_out[0]); end
    checks++;
    if (highs !== 96) begin errors++; $display("FAIL dbuf_new_duty highs got %0d want 96", highs); end
    rd(5'd1, d);
    checks++;
    if (d !== 8'h60) begin errors++; $display("FAIL dbuf_duty_read got %02h want 60", d); end
    pwm_ce = 1'b0;
    wr(5'd0, 8'h00);
  endtask

  task automatic test_resync();
    int bad = 0;
    wr(5'd1, 8'h40);
    wr(5'd3, 8'h40);
    wr(5'd0, 8'h80);
    pwm_ce = 1'b1;
    repeat (30) step();
    wr(5'd2, 8'h80);
    repeat (7) step();
    wr(5'd4, 8'h80);
    for (int k = 1; k <= 128; k++) begin
      step();
      if (pwm_out !== (((k - 1) < 64) ? 2'b11 : 2'b00)) bad++;
    end
    checks++;
    if (bad !== 0) begin errors++; $display("FAIL resync_aligned mismatched cycles got %0d want 0", bad); end
  endtask

  task automatic test_reset_mid();
    logic [7:0] d;
    repeat (10) step();
    checks++;
    if (pwm_out !== 2'b11) begin errors++; $display("FAIL pre_reset_high got %b want 11", pwm_out); end
    rst = 1'b1;
    csr_a = 5'd0;
    csr_di = 8'h80;
    csr_we = 1'b1;
    step();
    checks++;
    if (pwm_out !== 2'b00) begin errors++; $display("FAIL mid_reset_pwm_out got %b want 00", pwm_out); end
    rst = 1'b0;
    csr_we = 1'b0;
    for (int a = 0; a < 5; a++) begin
      rd(5'(a), d);
      checks++;
      if (d !== 8'h00) begin errors++; $display("FAIL mid_reset_read addr %0d got %02h want 00", a, d); end
    end
    checks++;
    if (pwm_out !== 2'b00) begin errors++; $display("FAIL post_reset_idle got %b want 00", pwm_out); end
    pwm_ce = 1'b0;
  endtask

  initial begin
    test_reset();
    test_ch0_basic();
    test_ch1_extremes();
    test_double_buffer();
    test_resync();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/pwm_multi.md
# pwm_multi

Multi-channel PWM generator on the 8-bit CPLD CSR bus; it replaces the single-channel PWM with CHANNELS independent outputs. Each channel has its own enable, prescale, output polarity and double-buffered duty cycle, updated glitch-free at period boundaries. A shared status/sync register reports pending updates and realigns all channel counters on demand. All channels advance on a common tick enable from the board timebase.

## Interface
- BASE_ADDR, 5'h0, first CSR address; block occupies BASE_ADDR .. BASE_ADDR+2*CHANNELS
- CHANNELS, 2, number of PWM channels, legal range 1..4
- clk  in  1  system clock; single clock domain
- rst  in  1  synchronous, active-high reset
- csr_a  in  5  CSR address
- csr_di  in  8  CSR write data
- csr_we  in  1  CSR write strobe, one cycle per write
- csr_do  out  8  CSR read data, registered
- pwm_ce  in  1  counter tick enable, one-cycle pulse
- pwm_out  out  CHANNELS  PWM outputs, registered, bit i = channel i

## Operation
- Per channel i, CTRL at BASE_ADDR+2i: [7] en, [6] inv, [5:2] read 0, [1:0] scale. Write takes effect next cycle.
- Per channel i, DUTY at BASE_ADDR+2i+1: 8-bit pending duty. Reads return the pending value, not the active value.
- STAT at BASE_ADDR+2*CHANNELS: read [CHANNELS-1:0] = pending flags, other bits 0. Writing with di[7]=1 resyncs; other write bits are ignored.
- Period P = 2^(7-scale) ticks: scale 0 -> 128, 1 -> 64, 2 -> 32, 3 -> 16.
- Counter: 7 bits per channel; advances only when pwm_ce=1 and en=1; counts 0..P-1, then wraps to 0.
- Raw output = (cnt < active_duty), computed at full 8-bit width. Duty 0 gives 0%. Duty >= P gives 100%, with no glitch at wrap.
- pwm_out[i] = inv ^ (en & raw). A disabled channel holds its idle level, which equals inv.
- Double buffering:
  - A DUTY write sets pending[i].
  - Active duty is loaded from pending, and pending[i] clears, on the cycle where pwm_ce=1 and cnt=P-1 (the wrap).
  - When en=0, active duty tracks pending continuously and pending[i] stays 0.
  - A DUTY write in the same cycle as a wrap: the old pending value is loaded, and the new value stays pending (pending[i]=1).
- Enable 0->1: counter cleared to 0, active duty loaded from pending, pending[i] cleared.
- Scale change while enabled: counter cleared to 0 and pending duty loaded, so a shortened period never leaves cnt >= P.
- Resync: all counters cleared to 0 and all pending duties loaded in the same cycle. Resync takes priority over a simultaneous pwm_ce.
- CSR read: csr_do <= register at csr_a every cycle; 0 for unmapped addresses. No read side effects.

## Timing
- Reset values: csr_do=0, pwm_out=0, all CTRL=0, DUTY pending/active=0, counters=0, pending flags=0.
- rst asserted mid-period forces the reset values on the next edge; it overrides csr_we, pwm_ce and resync.
- Read latency: 1 cycle. csr_do at edge N+1 reflects csr_a at edge N and includes any write committed at edge N.
- Counter updates at the pwm_ce edge. pwm_out reflects the new counter/duty one cycle later (registered output).
- CTRL write at edge N: new en/inv seen on pwm_out at edge N+1 (0% for the first cycle after enable, unless duty > 0, then high at N+1... see next item).
- Enable timing: counter is 0 at N, so with active_duty > 0 pwm_out goes to the active level at N+1.
- Duty change latency: at most one full period plus 1 clk after the DUTY write.
- Width rules: counter 7 bits, duty 8 bits, compare zero-extends the counter.

## Test plan
- Reset, then read every address (including STAT and one unmapped address) -> all 0x00; pwm_out=0.
- Ch0: scale=0, duty=0x40, en=1, pwm_ce every cycle -> pwm_out[0] high 64 cycles / low 64, period 128, repeating.
- Ch1: scale=3, duty=0x10; then duty=0x00; then inv=1 -> 100% high; then constant low; then constant high; no glitch at wrap.
- Ch0: running duty=0x20, write 0x60 mid-period -> STAT bit0=1 until the wrap; new duty applies only from the next period; STAT bit0 clears at the wrap.
- Two channels at different phases, write STAT 0x80 together with pwm_ce=1 -> both counters read 0; rising edges are coincident from then on.
- Assert rst mid-high-phase with en=1 -> next cycle pwm_out=0, CTRL/DUTY read 0x00.
